// File: rtl/stopwatch_run_ctrl.sv
// Run/stop sequencer for the BCD stopwatch: conditions the four buttons, runs the
// IDLE/RUN/PAUSE/EXPIRED machine and drives count enable, direction, clear, lap and alarm.
module stopwatch_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_W            = 20,
  parameter int ALARM_TICKS     = 30
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick_100ms,
  input  logic       start_button,
  input  logic       stop_button,
  input  logic       clear_button,
  input  logic       lap_button,
  input  logic       count_down,
  input  logic       at_zero,
  input  logic       at_max,
  output logic       running,
  output logic       direction,
  output logic       count_enable,
  output logic       clear_pulse,
  output logic       lap_hold,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  localparam int              NB         = 4;
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int              AW         = $clog2(ALARM_TICKS + 1);
  localparam logic [AW-1:0]   ALARM_LAST = AW'(ALARM_TICKS - 1);

  // Button lanes: 0 start, 1 stop, 2 clear, 3 lap.
  logic [NB-1:0]   raw;
  logic [NB-1:0]   sync_a;
  logic [NB-1:0]   sync_b;
  logic [NB-1:0]   db_level;
  logic [NB-1:0]   db_level_d;
  logic [NB-1:0]   press;
  logic [DB_W-1:0] db_cnt [NB];

  state_t        state_q;
  logic [AW-1:0] alarm_cnt;
  logic          terminal;
  logic          start_ev;
  logic          stop_ev;
  logic          clear_ev;
  logic          lap_ev;

  assign raw = {lap_button, clear_button, stop_button, start_button};

  assign start_ev = press[0];
  assign stop_ev  = press[1];
  assign clear_ev = press[2];
  assign lap_ev   = press[3];

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values,
  // independent of the order of statements or always blocks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_a     <= '0;
      sync_b     <= '0;
      db_level   <= '0;
      db_level_d <= '0;
      press      <= '0;
      // NOTE: db_cnt is a small flop array, not a RAM, so it takes the async reset
      // like any other register; a real memory would be left unreset.
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync_a     <= raw;
      sync_b     <= sync_a;
      db_level_d <= db_level;
      press      <= db_level & ~db_level_d;
      for (int i = 0; i < NB; i++) begin
        if (sync_b[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= sync_b[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    terminal     = 1'b0;
    count_enable = 1'b0;
    terminal     = direction ? at_max : at_zero;
    count_enable = (state_q == RUN) && tick_100ms && !terminal;
  end

  // Priority among coincident events is clear > stop > start; lap is handled alongside.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      running     <= 1'b0;
      direction   <= 1'b1;
      clear_pulse <= 1'b0;
      lap_hold    <= 1'b0;
      alarm       <= 1'b0;
      alarm_cnt   <= '0;
    end else begin
      clear_pulse <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_ev) begin
            clear_pulse <= 1'b1;
          end else if (start_ev && !stop_ev && !(count_down && at_zero)) begin
            state_q   <= RUN;
            running   <= 1'b1;
            direction <= ~count_down;
          end
        end
        RUN: begin
          if (clear_ev) begin
            state_q     <= IDLE;
            running     <= 1'b0;
            clear_pulse <= 1'b1;
            lap_hold    <= 1'b0;
          end else if (stop_ev) begin
            state_q <= PAUSE;
            running <= 1'b0;
            if (lap_ev) lap_hold <= ~lap_hold;
          end else if (terminal) begin
            // Only a countdown expiry raises the alarm.
            state_q   <= EXPIRED;
            running   <= 1'b0;
            lap_hold  <= 1'b0;
            alarm     <= ~direction;
            alarm_cnt <= '0;
          end else if (lap_ev) begin
            lap_hold <= ~lap_hold;
          end
        end
        PAUSE: begin
          if (clear_ev) begin
            state_q     <= IDLE;
            clear_pulse <= 1'b1;
            lap_hold    <= 1'b0;
          end else begin
            if (lap_ev) lap_hold <= 1'b0;
            if (start_ev && !stop_ev) begin
              state_q <= RUN;
              running <= 1'b1;
            end
          end
        end
        EXPIRED: begin
          if (clear_ev) begin
            state_q     <= IDLE;
            clear_pulse <= 1'b1;
            alarm       <= 1'b0;
            alarm_cnt   <= '0;
          end else if (alarm && tick_100ms) begin
            if (alarm_cnt == ALARM_LAST) begin
              alarm     <= 1'b0;
              alarm_cnt <= '0;
            end else begin
              alarm_cnt <= alarm_cnt + AW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Self-checking bench for stopwatch_run_ctrl: directed scenarios plus randomized button
// traffic, every cycle compared against a behavioural model built from the button rules.
module tb_stopwatch_run_ctrl;

  localparam int DEB   = 4;
  localparam int ALARM = 3;
  localparam int MAXC  = 8192;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_100ms = 1'b0;
  logic       start_button = 1'b0;
  logic       stop_button = 1'b0;
  logic       clear_button = 1'b0;
  logic       lap_button = 1'b0;
  logic       count_down = 1'b0;
  logic       at_zero = 1'b0;
  logic       at_max = 1'b0;
  logic       running;
  logic       direction;
  logic       count_enable;
  logic       clear_pulse;
  logic       lap_hold;
  logic       alarm;
  logic [1:0] state;

  stopwatch_run_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .DB_W            (4),
    .ALARM_TICKS     (ALARM)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tick_100ms   (tick_100ms),
    .start_button (start_button),
    .stop_button  (stop_button),
    .clear_button (clear_button),
    .lap_button   (lap_button),
    .count_down   (count_down),
    .at_zero      (at_zero),
    .at_max       (at_max),
    .running      (running),
    .direction    (direction),
    .count_enable (count_enable),
    .clear_pulse  (clear_pulse),
    .lap_hold     (lap_hold),
    .alarm        (alarm),
    .state        (state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_prob = 0;
  int ce_seen  = 0;
  int cp_seen  = 0;

  // Reference model: raw sample history per button, debounced level, and the
  // stopwatch behaviour expressed as state / direction / lap / remaining alarm ticks.
  logic raw_hist  [4][MAXC];
  logic rose_hist [4][MAXC];
  logic mdb [4];
  int   n;
  logic [1:0] ms;
  logic mdir;
  logic mcp;
  logic mlap;
  int   alarm_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic samp(input int b, input int k);
    if (k < 0) return 1'b0;
    return raw_hist[b][k];
  endfunction

  task automatic model_reset();
    n = 0;
    for (int b = 0; b < 4; b++) mdb[b] = 1'b0;
    ms = 2'd0; mdir = 1'b1; mcp = 1'b0; mlap = 1'b0; alarm_left = 0;
  endtask

  task automatic model_edge();
    logic [3:0] r;
    logic [3:0] ev;
    logic term;
    r = {lap_button, clear_button, stop_button, start_button};
    for (int b = 0; b < 4; b++) begin
      logic flip;
      raw_hist[b][n] = r[b];
      // Level accepted once the last DEB synchronised samples all disagree with it.
      flip = 1'b1;
      for (int k = n - DEB - 1; k <= n - 2; k++) if (samp(b, k) == mdb[b]) flip = 1'b0;
      if (flip) mdb[b] = ~mdb[b];
      rose_hist[b][n] = flip && mdb[b];
      ev[b] = (n >= 2) ? rose_hist[b][n-2] : 1'b0;
    end
    n++;
    term = mdir ? at_max : at_zero;
    mcp = 1'b0;
    case (ms)
      2'd0: begin
        if (ev[2]) mcp = 1'b1;
        else if (ev[0] && !ev[1] && !(count_down && at_zero)) begin ms = 2'd1; mdir = !count_down; end
      end
      2'd1: begin
        if (ev[2]) begin ms = 2'd0; mcp = 1'b1; mlap = 1'b0; end
        else if (ev[1]) begin ms = 2'd2; if (ev[3]) mlap = !mlap; end
        else if (term) begin ms = 2'd3; mlap = 1'b0; alarm_left = mdir ? 0 : ALARM; end
        else if (ev[3]) mlap = !mlap;
      end
      2'd2: begin
        if (ev[2]) begin ms = 2'd0; mcp = 1'b1; mlap = 1'b0; end
        else begin
          if (ev[3]) mlap = 1'b0;
          if (ev[0] && !ev[1]) ms = 2'd1;
        end
      end
      default: begin
        if (ev[2]) begin ms = 2'd0; mcp = 1'b1; alarm_left = 0; end
        else if (tick_100ms && alarm_left > 0) alarm_left--;
      end
    endcase
  endtask

  task automatic compare_all();
    logic mce;
    mce = (ms == 2'd1) && tick_100ms && !(mdir ? at_max : at_zero);
    check("state",        32'(state),        32'(ms));
    check("running",      32'(running),      32'(ms == 2'd1));
    check("direction",    32'(direction),    32'(mdir));
    check("count_enable", 32'(count_enable), 32'(mce));
    check("clear_pulse",  32'(clear_pulse),  32'(mcp));
    check("lap_hold",     32'(lap_hold),     32'(mlap));
    check("alarm",        32'(alarm),        32'(alarm_left > 0));
    if (count_enable) ce_seen++;
    if (clear_pulse)  cp_seen++;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step();
    if (tick_prob > 0) tick_100ms = ($urandom_range(tick_prob - 1) == 0);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: start_button = v;
      1: stop_button  = v;
      2: clear_button = v;
      default: lap_button = v;
    endcase
  endtask

  task automatic hold_button(input int b, input int cycles);
    set_btn(b, 1'b1);
    steps(cycles);
    set_btn(b, 1'b0);
    steps(8);
  endtask

  // Asserts reset between clock edges and checks the outputs before any edge arrives.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int hold_left [4];
    int pct [4];
    pct = '{40, 25, 10, 30};
    @(negedge clock);
    do_reset();

    // 1: glitches shorter than the debounce window, then a stable press.
    for (int g = 1; g <= 3; g++) begin
      start_button = 1'b1; steps(g);
      start_button = 1'b0; steps(1);
    end
    start_button = 1'b1;
    steps(7);
    check("t1_not_yet", 32'(running), 32'(0));
    steps(1);
    check("t1_running", 32'(running), 32'(1));
    start_button = 1'b0;
    steps(8);

    // 2: countdown run, terminal at zero, alarm for exactly ALARM ticks.
    do_reset();
    count_down = 1'b1;
    hold_button(0, 5);
    check("t2_direction", 32'(direction), 32'(0));
    check("t2_state_run", 32'(state), 32'(1));
    tick_prob = 2;
    steps(12);
    tick_prob = 0;
    tick_100ms = 1'b1;
    at_zero = 1'b1;
    #1 check("t2_ce_terminal", 32'(count_enable), 32'(0));
    step();
    tick_100ms = 1'b0;
    check("t2_expired", 32'(state), 32'(3));
    for (int i = 0; i < ALARM; i++) begin
      check("t2_alarm_hi", 32'(alarm), 32'(1));
      tick_100ms = 1'b1; step();
      tick_100ms = 1'b0; step();
    end
    check("t2_alarm_lo", 32'(alarm), 32'(0));
    hold_button(2, 5);
    at_zero = 1'b0;
    count_down = 1'b0;

    // 3: start and clear together in PAUSE.
    do_reset();
    hold_button(0, 5);
    hold_button(1, 5);
    check("t3_pause", 32'(state), 32'(2));
    cp_seen = 0;
    start_button = 1'b1; clear_button = 1'b1;
    steps(5);
    start_button = 1'b0; clear_button = 1'b0;
    steps(8);
    check("t3_idle", 32'(state), 32'(0));
    check("t3_one_clear", 32'(cp_seen), 32'(1));

    // 4: lap toggling while counting, then stop and clear.
    do_reset();
    hold_button(0, 5);
    tick_prob = 2;
    ce_seen = 0;
    hold_button(3, 5);
    check("t4_lap_on", 32'(lap_hold), 32'(1));
    check("t4_ce_pulsing", 32'(ce_seen > 0), 32'(1));
    hold_button(3, 5);
    check("t4_lap_off", 32'(lap_hold), 32'(0));
    hold_button(3, 5);
    hold_button(1, 5);
    check("t4_lap_paused", 32'(lap_hold), 32'(1));
    hold_button(2, 5);
    check("t4_lap_cleared", 32'(lap_hold), 32'(0));
    check("t4_idle", 32'(state), 32'(0));

    // 5: countdown start at zero is refused; up-count expiry has no alarm.
    do_reset();
    count_down = 1'b1; at_zero = 1'b1;
    ce_seen = 0;
    hold_button(0, 5);
    check("t5_stay_idle", 32'(state), 32'(0));
    check("t5_no_ce", 32'(ce_seen), 32'(0));
    count_down = 1'b0; at_zero = 1'b0;
    hold_button(0, 5);
    at_max = 1'b1;
    steps(2);
    check("t5_expired", 32'(state), 32'(3));
    check("t5_no_alarm", 32'(alarm), 32'(0));
    at_max = 1'b0;
    hold_button(2, 5);
    tick_prob = 0; tick_100ms = 1'b0;

    // 6: async reset mid-run, then a full debounce before the next start.
    do_reset();
    count_down = 1'b1;
    hold_button(0, 5);
    hold_button(3, 5);
    check("t6_pre_lap", 32'(lap_hold), 32'(1));
    check("t6_pre_dir", 32'(direction), 32'(0));
    tick_100ms = 1'b1;
    do_reset();
    tick_100ms = 1'b0;
    start_button = 1'b1;
    steps(7);
    check("t6_not_yet", 32'(running), 32'(0));
    steps(1);
    check("t6_running", 32'(running), 32'(1));
    start_button = 1'b0;
    steps(8);

    // Randomized traffic: button levels held for random spans, sporadic limits and resets.
    tick_prob = 3;
    for (int b = 0; b < 4; b++) hold_left[b] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold_left[b] == 0) begin
          set_btn(b, $urandom_range(99) < pct[b]);
          hold_left[b] = $urandom_range(12, 1);
        end else begin
          hold_left[b]--;
        end
      end
      at_zero = ($urandom_range(19) == 0);
      at_max  = ($urandom_range(19) == 0);
      if ($urandom_range(49) == 0) count_down = ~count_down;
      if ($urandom_range(999) == 0) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
